// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared constants and loader state type for the risc core slice
package risc_pkg;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          IMEM_ADDR_W = 8;

  typedef enum logic {
    LD_LOAD = 1'b0,
    LD_RUN  = 1'b1
  } ld_state_e;
endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte lane, strobes, fetch port and status of the program loader
interface imem_loader_if;
  import risc_pkg::*;

  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic                   load_done;
  logic                   reload;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_data;
  logic                   core_rst_n;
  logic [8:0]             words_loaded;
  logic                   busy;

  modport master (
    output byte_in, byte_valid, load_done, reload, imem_addr,
    input  imem_data, core_rst_n, words_loaded, busy
  );

  modport slave (
    input  byte_in, byte_valid, load_done, reload, imem_addr,
    output imem_data, core_rst_n, words_loaded, busy
  );
endinterface

// File: rtl/imem_store.sv
// rtl/imem_store.sv - DEPTHx32 instruction array, sync write, comb read, NOP outside range
module imem_store
  import risc_pkg::*;
#(
  parameter int          DEPTH = 16,
  parameter logic [31:0] NOP   = NOP_INSTR,
  localparam int         AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [31:0]            i_wdata,
  input  logic [IMEM_ADDR_W-1:0] i_raddr,
  output logic [31:0]            o_rdata
);
  logic [31:0] r_mem [DEPTH];
  logic        w_in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= NOP;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Widen by one bit so DEPTH=256 compares correctly against an 8-bit address
  assign w_in_range = ({1'b0, i_raddr} < 9'(DEPTH));
  assign o_rdata    = w_in_range ? r_mem[i_raddr[AW-1:0]] : NOP;
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-serial program loader holding the core in reset until loaded
module imem_loader
  import risc_pkg::*;
#(
  parameter int          DEPTH = 16,
  parameter logic [31:0] NOP   = NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  ld_state_e     r_state, w_state_nxt;
  logic [1:0]    r_idx;
  logic [23:0]   r_buf;
  logic [AW-1:0] r_wr_ptr;
  logic [8:0]    r_words;
  logic          w_consume, w_word_done, w_last;
  logic [31:0]   w_wdata, w_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= LD_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_consume   = 1'b0;
    w_word_done = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      LD_LOAD: begin
        w_consume   = bus.byte_valid;
        w_word_done = w_consume && (r_idx == 2'd3);
        w_last      = w_word_done && (r_wr_ptr == AW'(DEPTH - 1));
        if (bus.load_done || w_last) w_state_nxt = LD_RUN;
      end
      LD_RUN: begin
        if (bus.reload) w_state_nxt = LD_LOAD;
      end
    endcase
  end

  // Leaving LOAD drops any partial word; a completing byte is still written first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx    <= 2'd0;
      r_buf    <= '0;
      r_wr_ptr <= '0;
      r_words  <= '0;
    end else if (r_state == LD_LOAD) begin
      if (w_state_nxt == LD_RUN) begin
        r_idx <= 2'd0;
        r_buf <= '0;
      end else if (w_consume) begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd0:    r_buf[7:0]   <= bus.byte_in;
          2'd1:    r_buf[15:8]  <= bus.byte_in;
          2'd2:    r_buf[23:16] <= bus.byte_in;
          default: r_buf        <= '0;
        endcase
      end
      if (w_word_done) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_words  <= r_words + 9'd1;
      end
    end else if (bus.reload) begin
      r_idx    <= 2'd0;
      r_buf    <= '0;
      r_wr_ptr <= '0;
      r_words  <= '0;
    end
  end

  assign w_wdata = {bus.byte_in, r_buf};

  imem_store #(
    .DEPTH (DEPTH),
    .NOP   (NOP)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_word_done),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (bus.imem_addr),
    .o_rdata (w_rdata)
  );

  assign bus.imem_data    = w_rdata;
  assign bus.core_rst_n   = (r_state == LD_RUN);
  assign bus.busy         = (r_state != LD_RUN);
  assign bus.words_loaded = r_words;
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial program loader and instruction store that sits directly upstream of the `risc` core's fetch port. While loading, it holds the core in reset and assembles incoming bytes into 32-bit words in an internal instruction memory. After loading, it releases the core and serves `INSTRUCTION_MEM_OUT` combinationally from the core's 8-bit fetch address. It fits the Tiny Tapeout 8-bit pin budget: one input byte lane plus a few strobes.

## Interface

Parameters:
- `DEPTH`, 16: words of instruction storage; power of two, 2..256.
- `NOP`, 32'h00000013: word returned for out-of-range fetches and for unwritten entries after reset (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset. The sole reset of this block.
- `byte_in` in 8: program byte.
- `byte_valid` in 1: `byte_in` is consumed this cycle (LOAD state only).
- `load_done` in 1: ends loading; enter RUN.
- `reload` in 1: from RUN, return to LOAD.
- `imem_addr` in 8: core fetch address (core `INSTRUCTION_MEM_IN`).
- `imem_data` out 32: instruction (core `INSTRUCTION_MEM_OUT`).
- `core_rst_n` out 1: drives core `rst_n`; low while loading.
- `words_loaded` out 9: words written since entering LOAD (0..DEPTH).
- `busy` out 1: high in LOAD.

## Operation

- States: LOAD and RUN. Reset enters LOAD.
- Reset values:
  - state=LOAD, `core_rst_n`=0, `busy`=1, `words_loaded`=0.
  - Byte index=0, write pointer=0, assembly buffer=0.
  - Every memory entry=`NOP`.
- Byte assembly in LOAD, on each `byte_valid`:
  - Little-endian. The byte at index k goes to buffer bits [8k+7:8k].
  - The index increments mod 4.
  - When index 3 is consumed, the full word is written to `mem[wr_ptr]`, `wr_ptr` and `words_loaded` increment, and the index returns to 0.
- LOAD → RUN occurs on either:
  - `load_done`=1, or
  - the write of entry `DEPTH-1` (auto-finish).

  On entering RUN, the byte index and buffer are cleared. Any partial word (1–3 bytes) is discarded, never written.
- Simultaneous `byte_valid` and `load_done`: the byte is consumed first. If it completes a word, that word is written, then the state moves to RUN on the same edge.
- RUN:
  - `byte_valid` and `load_done` are ignored.
  - `reload`=1 → LOAD with write pointer=0, index=0, `words_loaded`=0.
  - Memory contents are retained on reload and overwritten only as new words arrive.
- `reload` in LOAD is ignored.
- Fetch:
  - `imem_data` = `mem[imem_addr]` when `imem_addr` < `DEPTH`, otherwise `NOP`.
  - Pure combinational read, valid in both states. The core samples it only in RUN.
- `core_rst_n` = (state==RUN), decoded directly from the state flop so it is glitch-free. `busy` = `~core_rst_n`.
- `rst_n` low mid-load or mid-run: the full reset values apply on that edge, including memory reinitialised to `NOP`.

## Timing

- Byte consumption: 1 byte/cycle sustained. The memory write lands on the same edge that consumes byte 3, so it is visible on `imem_data` the next cycle.
- `load_done` sampled at edge N: `core_rst_n`=1 from cycle N+1. The core's first fetch (PC=0) sees the fully written memory.
- Auto-finish: the edge writing entry `DEPTH-1` also sets RUN. Bytes after that edge are ignored.
- `reload` sampled at edge N: `core_rst_n`=0 from cycle N+1. The core's synchronous reset takes effect at edge N+1.
- Fetch read latency: 0 cycles, combinational from `imem_addr`.
- `words_loaded` saturates naturally at `DEPTH` because of auto-finish. It never wraps.

## Structure

- Shared `risc_pkg`:
  - `NOP_INSTR` constant (32'h00000013).
  - `IMEM_ADDR_W`=8.
  - A loader state enum {`LD_LOAD`, `LD_RUN`}.
- One natural sub-module, `imem_store`: a `DEPTH`x32 register array with a synchronous write port, a combinational read port with out-of-range `NOP`, and a synchronous reset to `NOP`.
- The loader FSM, byte assembler and counters stay in `imem_loader`.

## Test plan

- Reset, then bytes 13 05 50 00 93 05 60 00 at one per cycle, then `load_done`:
  - Required: `mem[0]`=0x00500513, `mem[1]`=0x00600593, `words_loaded`=2, and `core_rst_n` rises the cycle after `load_done`.
  - Fetch `imem_addr`=1 → 0x00600593; `imem_addr`=2 → 0x00000013.
- 6 bytes (one full word plus 2), then `load_done`:
  - Required: `words_loaded`=1, `mem[1]` stays `NOP`.
  - A subsequent `reload` plus 4 bytes AA BB CC DD writes 0xDDCCBBAA to `mem[0]`.
- 4·`DEPTH`+4 bytes with no `load_done`:
  - Required: RUN is entered on the 64th byte (`DEPTH`=16), `words_loaded`=16, and the last 4 bytes change nothing.
  - `imem_addr`=200 → `NOP`.
- `load_done` in the same cycle as the 4th byte of word 0:
  - Required: the word is written, RUN is entered, and `words_loaded`=1.
- `reload` in RUN after a program is loaded:
  - Required: `core_rst_n`=0 next cycle and old words still readable.
  - A new word overwrites only `mem[0]`.
- `rst_n` low for one cycle after 3 words are loaded:
  - Required: `core_rst_n`=0, `words_loaded`=0, and `imem_addr`=0..2 → `NOP`.
